gpio_pin_ctrl: RTL and testbench

Parametrised GPIO controller that replaces fixed per-pin direction/output wiring with a register-mapped block. It adds input synchronisation, programmable debounce, per-pin rising/falling edge detection and a latched interrupt. It sits between the MMIO register bus and the board-level tristate pin buffers, which stay in the top-level wrapper.

---
 rtl/gpio_pkg.sv | 15 +
 rtl/gpio_pin_debounce.sv | 61 ++++++
 rtl/gpio_pin_ctrl.sv | 119 +++++++++++
 tb/tb_gpio_pin_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO pin controller:
// register map and debounce confirmation depth.
package gpio_pkg;

  localparam logic [2:0] GPIO_REG_OUT  = 3'd0;
  localparam logic [2:0] GPIO_REG_DIR  = 3'd1;
  localparam logic [2:0] GPIO_REG_IN   = 3'd2;
  localparam logic [2:0] GPIO_REG_RISE = 3'd3;
  localparam logic [2:0] GPIO_REG_FALL = 3'd4;
  localparam logic [2:0] GPIO_REG_PEND = 3'd5;
  localparam logic [2:0] GPIO_REG_DBNC = 3'd6;

  localparam int unsigned GPIO_DB_CONFIRM = 3;

endpackage

// File: rtl/gpio_pin_debounce.sv
// One GPIO input: 2-flop synchroniser, tick-based
// debounce filter and raw edge flags on the filtered level.
module gpio_pin_debounce (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  input  logic tick_i,
  input  logic bypass_i,
  input  logic clr_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  import gpio_pkg::*;

  logic       s1_q, s2_q;
  logic       stable_q, stable_d;
  logic       prev_q;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (bypass_i) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (s2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == 2'(GPIO_DB_CONFIRM - 1)) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= pin_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~prev_q;
  assign fall_o   = ~stable_q & prev_q;

endmodule

// File: rtl/gpio_pin_ctrl.sv
// Register-mapped GPIO block: output/direction registers,
// debounced inputs, edge-enable masks, W1C pending and irq.
module gpio_pin_ctrl #(
  parameter int NPINS = 16,
  parameter int DBW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NPINS-1:0] pinsIn,
  output logic [NPINS-1:0] pinsOut,
  output logic [NPINS-1:0] pinsDir,
  input  logic [2:0]       regAddr,
  input  logic             regWrEn,
  input  logic             regRdEn,
  input  logic [31:0]      regWrData,
  output logic [31:0]      regRdData,
  output logic             regOK,
  output logic             irq
);
  import gpio_pkg::*;

  logic [NPINS-1:0] out_q, dir_q, rise_en_q, fall_en_q;
  logic [NPINS-1:0] pend_q, pend_d, w1c;
  logic [NPINS-1:0] stable, rise, fall, wdata;
  logic [DBW-1:0]   dbnc_q, presc_q, presc_d;
  logic [31:0]      rdata_q, rd_val;
  logic             ok_q, irq_q;
  logic             tick, bypass, wr_dbnc;
  logic             unused_wdata;

  assign wdata        = regWrData[NPINS-1:0];
  assign unused_wdata = ^regWrData;
  assign bypass       = dbnc_q == '0;
  assign tick         = !bypass && presc_q == '0;
  assign wr_dbnc      = regWrEn && regAddr == GPIO_REG_DBNC;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    gpio_pin_debounce u_db (
      .clock    (clock),
      .reset    (reset),
      .pin_i    (pinsIn[i]),
      .tick_i   (tick),
      .bypass_i (bypass),
      .clr_i    (wr_dbnc),
      .stable_o (stable[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  always_comb begin
    presc_d = presc_q;
    if (wr_dbnc) presc_d = regWrData[DBW-1:0];
    else if (bypass) presc_d = '0;
    else if (tick) presc_d = dbnc_q;
    else presc_d = presc_q - 1'b1;
  end

  // a fresh edge overrides a simultaneous clear of the same bit
  always_comb begin
    w1c = '0;
    if (regWrEn && regAddr == GPIO_REG_PEND) w1c = wdata;
    pend_d = (pend_q & ~w1c)
           | (rise & rise_en_q)
           | (fall & fall_en_q);
  end

  always_comb begin
    rd_val = '0;
    unique case (regAddr)
      GPIO_REG_OUT:  rd_val = 32'(out_q);
      GPIO_REG_DIR:  rd_val = 32'(dir_q);
      GPIO_REG_IN:   rd_val = 32'(stable);
      GPIO_REG_RISE: rd_val = 32'(rise_en_q);
      GPIO_REG_FALL: rd_val = 32'(fall_en_q);
      GPIO_REG_PEND: rd_val = 32'(pend_q);
      GPIO_REG_DBNC: rd_val = 32'(dbnc_q);
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      dbnc_q    <= '0;
      presc_q   <= '0;
      rdata_q   <= '0;
      ok_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (regWrEn) begin
        unique case (regAddr)
          GPIO_REG_OUT:  out_q     <= wdata;
          GPIO_REG_DIR:  dir_q     <= wdata;
          GPIO_REG_RISE: rise_en_q <= wdata;
          GPIO_REG_FALL: fall_en_q <= wdata;
          GPIO_REG_DBNC: dbnc_q    <= regWrData[DBW-1:0];
          default: ;
        endcase
      end
      pend_q  <= pend_d;
      presc_q <= presc_d;
      ok_q    <= regWrEn | regRdEn;
      rdata_q <= regRdEn ? rd_val : '0;
      irq_q   <= |pend_q;
    end
  end

  assign pinsOut   = out_q;
  assign pinsDir   = dir_q;
  assign regRdData = rdata_q;
  assign regOK     = ok_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Directed plus randomized bench for gpio_pin_ctrl with
// a latency-based reference model for bypass-mode edges.
module tb_gpio_pin_ctrl;
  import gpio_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pinsIn, pinsOut, pinsDir;
  logic [2:0]  regAddr;
  logic        regWrEn, regRdEn, regOK, irq;
  logic [31:0] regWrData, regRdData;

  int checks   = 0;
  int failures = 0;

  gpio_pin_ctrl #(.NPINS(16), .DBW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .pinsIn    (pinsIn),
    .pinsOut   (pinsOut),
    .pinsDir   (pinsDir),
    .regAddr   (regAddr),
    .regWrEn   (regWrEn),
    .regRdEn   (regRdEn),
    .regWrData (regWrData),
    .regRdData (regRdData),
    .regOK     (regOK),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    regAddr = a; regWrData = d; regWrEn = 1'b1;
    @(negedge clock);
    regWrEn = 1'b0;
    chk("wr_ok", 32'(regOK), 32'd1);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clock);
    regAddr = a; regRdEn = 1'b1;
    @(negedge clock);
    regRdEn = 1'b0;
    chk("rd_ok", 32'(regOK), 32'd1);
    d = regRdData;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a,
                       input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  function automatic logic [31:0] rw_mask(input logic [2:0] a);
    return (a == GPIO_REG_DBNC) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  logic [2:0]  rw_addr [5];
  logic [31:0] mreg [8];
  logic [15:0] hist [$];
  logic [15:0] mp, re, fe, v0, a4, a3;

  initial begin
    rw_addr = '{GPIO_REG_OUT, GPIO_REG_DIR, GPIO_REG_RISE,
                GPIO_REG_FALL, GPIO_REG_DBNC};
    reset = 1'b1; pinsIn = '0; regAddr = '0;
    regWrEn = 1'b0; regRdEn = 1'b0; regWrData = '0;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_out", 32'(pinsOut), 32'h0);
    chk("rst_dir", 32'(pinsDir), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ok", 32'(regOK), 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rdchk("rst_rd", 3'(a), 32'h0);
    @(negedge clock);
    chk("ok_pulse", 32'(regOK), 32'h0);
    chk("rdata_idle", regRdData, 32'h0);

    // basic register access
    wr(GPIO_REG_DIR, 32'h0000_00FF);
    chk("dir_out", 32'(pinsDir), 32'h0000_00FF);
    wr(GPIO_REG_OUT, 32'hABCD_00A5);
    chk("out_out", 32'(pinsOut), 32'h0000_00A5);
    rdchk("out_rd", GPIO_REG_OUT, 32'h0000_00A5);
    rdchk("dir_rd", GPIO_REG_DIR, 32'h0000_00FF);
    wr(3'd7, 32'hFFFF_FFFF);
    rdchk("a7_rd", 3'd7, 32'h0);

    // simultaneous write and read: read sees pre-write value
    @(negedge clock);
    regAddr = GPIO_REG_OUT; regWrData = 32'h1234;
    regWrEn = 1'b1; regRdEn = 1'b1;
    @(negedge clock);
    regWrEn = 1'b0; regRdEn = 1'b0;
    chk("wrrd_ok", 32'(regOK), 32'd1);
    chk("wrrd_data", regRdData, 32'h0000_00A5);
    chk("wrrd_out", 32'(pinsOut), 32'h0000_1234);

    // randomized register read/write against an array model
    foreach (mreg[i]) mreg[i] = '0;
    mreg[GPIO_REG_OUT] = 32'h1234;
    mreg[GPIO_REG_DIR] = 32'h00FF;
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  a;
      logic [31:0] d, v;
      a = rw_addr[$urandom_range(0, 4)];
      d = $urandom;
      wr(a, d);
      mreg[a] = d & rw_mask(a);
      chk("rnd_pins_out", 32'(pinsOut), mreg[GPIO_REG_OUT]);
      chk("rnd_pins_dir", 32'(pinsDir), mreg[GPIO_REG_DIR]);
      a = rw_addr[$urandom_range(0, 4)];
      rd(a, v);
      chk("rnd_rd", v, mreg[a]);
    end

    // bypass latency on pin 0
    wr(GPIO_REG_DBNC, 32'h0);
    wr(GPIO_REG_RISE, 32'h0);
    wr(GPIO_REG_FALL, 32'h0);
    @(negedge clock); pinsIn = 16'h0002;
    repeat (5) @(negedge clock);
    wr(GPIO_REG_PEND, 32'hFFFF);
    wr(GPIO_REG_RISE, 32'h0001);
    @(negedge clock); pinsIn[0] = 1'b1;
    @(negedge clock);
    @(negedge clock); regAddr = GPIO_REG_IN; regRdEn = 1'b1;
    @(negedge clock);
    chk("byp_in_t2", regRdData, 32'h2);
    @(negedge clock);
    chk("byp_in_t3", regRdData, 32'h3);
    chk("byp_irq_t3", 32'(irq), 32'h0);
    regAddr = GPIO_REG_PEND;
    @(negedge clock);
    chk("byp_pend", regRdData, 32'h1);
    chk("byp_irq_t4", 32'(irq), 32'h1);
    regRdEn = 1'b0;
    wr(GPIO_REG_PEND, 32'h1);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    @(negedge clock);
    chk("w1c_irq_drop", 32'(irq), 32'h0);

    // debounce: short glitch rejected, long low accepted
    wr(GPIO_REG_DBNC, 32'h4);
    wr(GPIO_REG_FALL, 32'h2);
    @(negedge clock); pinsIn[1] = 1'b0;
    repeat (6) @(negedge clock);
    pinsIn[1] = 1'b1;
    repeat (30) @(negedge clock);
    rdchk("glitch_in", GPIO_REG_IN, 32'h3);
    rdchk("glitch_pend", GPIO_REG_PEND, 32'h0);
    @(negedge clock); pinsIn[1] = 1'b0;
    repeat (6) @(negedge clock);
    rdchk("db_early_in", GPIO_REG_IN, 32'h3);
    repeat (20) @(negedge clock);
    rdchk("db_in", GPIO_REG_IN, 32'h1);
    rdchk("db_pend", GPIO_REG_PEND, 32'h2);
    chk("db_irq", 32'(irq), 32'h1);

    // new edge and W1C on the same bit in the same cycle
    wr(GPIO_REG_DBNC, 32'h0);
    wr(GPIO_REG_FALL, 32'h3);
    @(negedge clock); pinsIn[0] = 1'b0;
    repeat (3) @(negedge clock);
    regAddr = GPIO_REG_PEND; regWrData = 32'h3; regWrEn = 1'b1;
    @(negedge clock);
    regWrEn = 1'b0;
    rdchk("set_wins", GPIO_REG_PEND, 32'h1);

    // random pin traffic in bypass vs latency model
    re = 16'($urandom); fe = 16'($urandom);
    wr(GPIO_REG_RISE, 32'(re));
    wr(GPIO_REG_FALL, 32'(fe));
    v0 = pinsIn;
    wr(GPIO_REG_PEND, 32'hFFFF);
    hist = {};
    repeat (5) hist.push_back(v0);
    mp = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      chk("rand_irq", 32'(irq), 32'(|mp));
      a4 = hist[hist.size() - 5];
      a3 = hist[hist.size() - 4];
      mp = mp | (re & ~a4 & a3) | (fe & a4 & ~a3);
      if (c < 50) pinsIn = 16'($urandom);
      hist.push_back(pinsIn);
    end
    rdchk("rand_pend", GPIO_REG_PEND, 32'(mp));
    rdchk("rand_in", GPIO_REG_IN, 32'(pinsIn));

    // reset mid-debounce with edges pending
    wr(GPIO_REG_PEND, 32'hFFFF);
    wr(GPIO_REG_RISE, 32'h3);
    wr(GPIO_REG_FALL, 32'h0);
    @(negedge clock); pinsIn = 16'h0000;
    repeat (6) @(negedge clock);
    wr(GPIO_REG_PEND, 32'hFFFF);
    @(negedge clock); pinsIn = 16'h0003;
    repeat (6) @(negedge clock);
    rdchk("pre_rst_pend", GPIO_REG_PEND, 32'h3);
    wr(GPIO_REG_OUT, 32'hF0F0);
    wr(GPIO_REG_DIR, 32'hFFFF);
    wr(GPIO_REG_DBNC, 32'h4);
    @(negedge clock); pinsIn = 16'h0000;
    repeat (4) @(negedge clock);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out", 32'(pinsOut), 32'h0);
    chk("arst_dir", 32'(pinsDir), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_ok", 32'(regOK), 32'h0);
    chk("arst_rdata", regRdData, 32'h0);
    @(negedge clock); reset = 1'b0;
    rdchk("post_in", GPIO_REG_IN, 32'h0);
    rdchk("post_pend", GPIO_REG_PEND, 32'h0);
    rdchk("post_dbnc", GPIO_REG_DBNC, 32'h0);
    repeat (20) @(negedge clock);
    rdchk("post_in_late", GPIO_REG_IN, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
